// File: rtl/dsp_acc_unpack.sv
// Splits the packed dual-lane accumulator word into two pixels: borrow undo, rounding, clamp.
// Defining DSP_UNPACK_SAT_FLAG_EN adds the m_sat / sat_sticky saturation outputs.
module dsp_acc_unpack #(
  parameter int LOW_WIDTH = 24,
  parameter int FRAC_BITS = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 dsp_reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [47:0]          s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_low,
  output logic [OUT_WIDTH-1:0] m_high
`ifdef DSP_UNPACK_SAT_FLAG_EN
  ,
  output logic [1:0]           m_sat,
  output logic [1:0]           sat_sticky
`endif
);

  localparam int HIGH_W = 48 - LOW_WIDTH;
  // Both lanes are carried at one common width; a wide margin makes every add exact.
  localparam int LANE_W = 49;
  localparam logic signed [LANE_W-1:0] HALF    = LANE_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [LANE_W-1:0] PIX_MAX = (LANE_W'(1) << OUT_WIDTH) - LANE_W'(1);

  function automatic logic signed [LANE_W-1:0] round_lane(input logic signed [LANE_W-1:0] x);
    return (x + HALF) >>> FRAC_BITS;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] clamp_lane(input logic signed [LANE_W-1:0] x);
    if (x[LANE_W-1])     return '0;
    else if (x > PIX_MAX) return '1;
    else                 return x[OUT_WIDTH-1:0];
  endfunction

`ifdef DSP_UNPACK_SAT_FLAG_EN
  function automatic logic is_clamped(input logic signed [LANE_W-1:0] x);
    return x[LANE_W-1] || (x > PIX_MAX);
  endfunction
`endif

  logic                      vld_p0, vld_p1, vld_p2;
  logic                      rdy_p0, rdy_p1, rdy_p2;
  logic signed [LANE_W-1:0]  lo_split, hi_split;
  logic signed [LANE_W-1:0]  lo_p0, hi_p0, lo_p1, hi_p1;
  logic [OUT_WIDTH-1:0]      pix_lo_p2, pix_hi_p2;
`ifdef DSP_UNPACK_SAT_FLAG_EN
  logic [1:0]                sat_p2;
`endif

  assign rdy_p2 = !vld_p2 || m_ready;
  assign rdy_p1 = !vld_p1 || rdy_p2;
  assign rdy_p0 = !vld_p0 || rdy_p1;

  assign s_ready = rdy_p0 && !dsp_reset;
  assign m_valid = vld_p2 && !dsp_reset;
  assign m_low   = pix_lo_p2;
  assign m_high  = pix_hi_p2;
`ifdef DSP_UNPACK_SAT_FLAG_EN
  assign m_sat   = sat_p2;
`endif

  // A negative low lane borrowed one from the high field when packed; add it back.
  always_comb begin
    lo_split = '0;
    hi_split = '0;
    lo_split = {{(LANE_W-LOW_WIDTH){s_data[LOW_WIDTH-1]}}, s_data[LOW_WIDTH-1:0]};
    hi_split = {{(LANE_W-HIGH_W){s_data[47]}}, s_data[47:LOW_WIDTH]}
               + LANE_W'(s_data[LOW_WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (dsp_reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      lo_p0     <= '0;
      hi_p0     <= '0;
      lo_p1     <= '0;
      hi_p1     <= '0;
      pix_lo_p2 <= '0;
      pix_hi_p2 <= '0;
`ifdef DSP_UNPACK_SAT_FLAG_EN
      sat_p2    <= '0;
`endif
    end else begin
      // S1: lane split and borrow compensation
      if (rdy_p0) begin
        vld_p0 <= s_valid;
        if (s_valid) begin
          lo_p0 <= lo_split;
          hi_p0 <= hi_split;
        end
      end
      // S2: round-half-up and drop fractional bits
      if (rdy_p1) begin
        vld_p1 <= vld_p0;
        if (vld_p0) begin
          lo_p1 <= round_lane(lo_p0);
          hi_p1 <= round_lane(hi_p0);
        end
      end
      // S3: clamp to the pixel range and hold for the output handshake
      if (rdy_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          pix_lo_p2 <= clamp_lane(lo_p1);
          pix_hi_p2 <= clamp_lane(hi_p1);
`ifdef DSP_UNPACK_SAT_FLAG_EN
          sat_p2    <= {is_clamped(hi_p1), is_clamped(lo_p1)};
`endif
        end
      end
    end
  end

`ifdef DSP_UNPACK_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (dsp_reset)            sat_sticky <= '0;
    else if (m_valid && m_ready) sat_sticky <= sat_sticky | sat_p2;
  end
`endif

endmodule
